// File: rtl/bath_mode_sequencer_if.sv
// Key inputs and display/actuator outputs of the bath heater mode sequencer.
interface bath_mode_sequencer_if;
  logic       key_power;
  logic [3:0] key_mode;
  logic [1:0] on_st;
  logic [3:0] mode_cur;
  logic [2:0] delay_sec;
  logic       fan_en;
  logic       heat_lo;
  logic       heat_hi;

  modport master (
    output key_power, key_mode,
    input  on_st, mode_cur, delay_sec, fan_en, heat_lo, heat_hi
  );

  modport slave (
    input  key_power, key_mode,
    output on_st, mode_cur, delay_sec, fan_en, heat_lo, heat_hi
  );
endinterface

// File: rtl/bath_mode_sequencer.sv
// Bath heater power/mode sequencer: self-test, staged heater engage (fan first),
// and fan cooldown after power-off from a heating mode.
module bath_mode_sequencer #(
  parameter int unsigned SELFTEST_MS = 2000,
  parameter int unsigned SEC_MS      = 1000,
  parameter int unsigned COOLDOWN_S  = 3
) (
  input logic                  clk_1kHz,
  input logic                  rst,
  bath_mode_sequencer_if.slave bus
);
  localparam int unsigned MAX_MS = (SELFTEST_MS > SEC_MS) ? SELFTEST_MS : SEC_MS;
  localparam int unsigned CNT_W  = (MAX_MS > 1) ? $clog2(MAX_MS) : 1;
  localparam int unsigned DLY_W  = 3;
  localparam int unsigned MODE_W = 4;

  localparam logic [CNT_W-1:0]  SELFTEST_END = CNT_W'(SELFTEST_MS - 1);
  localparam logic [CNT_W-1:0]  SEC_END      = CNT_W'(SEC_MS - 1);
  localparam logic [DLY_W-1:0]  COOL_LOAD    = DLY_W'(COOLDOWN_S);
  localparam logic [DLY_W-1:0]  WARM_DLY     = DLY_W'(2);
  localparam logic [DLY_W-1:0]  STRONG_DLY   = DLY_W'(4);
  localparam logic [DLY_W-1:0]  STRONG_LO_AT = DLY_W'(3);
  localparam logic [DLY_W-1:0]  DLY_ONE      = DLY_W'(1);
  localparam logic [MODE_W-1:0] MODE_NONE    = MODE_W'(0);

  typedef enum logic [2:0] {
    S_OFF, S_SELFTEST, S_RUN, S_STAGE, S_COOLDOWN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        on_st_q, on_st_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [DLY_W-1:0]  delay_q, delay_d;
  logic              fan_q, fan_d;
  logic              heat_lo_q, heat_lo_d;
  logic              heat_hi_q, heat_hi_d;

  logic pwr_c, req_c, same_c, staged_c, st_end_c, sec_end_c;

  // Key decode: only single-bit mode requests are valid; power wins by priority below.
  assign pwr_c     = bus.key_power;
  assign req_c     = $onehot(bus.key_mode);
  assign same_c    = (bus.key_mode == mode_q);
  assign staged_c  = bus.key_mode[1] | bus.key_mode[2];
  assign st_end_c  = (cnt_q == SELFTEST_END);
  assign sec_end_c = (cnt_q == SEC_END);

  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      on_st_q   <= 2'b00;
      mode_q    <= MODE_NONE;
      delay_q   <= '0;
      fan_q     <= 1'b0;
      heat_lo_q <= 1'b0;
      heat_hi_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      on_st_q   <= on_st_d;
      mode_q    <= mode_d;
      delay_q   <= delay_d;
      fan_q     <= fan_d;
      heat_lo_q <= heat_lo_d;
      heat_hi_q <= heat_hi_d;
    end
  end

  // Next state and ms counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_OFF: begin
        if (pwr_c) begin
          state_d = S_SELFTEST;
          cnt_d   = '0;
        end
      end
      S_SELFTEST: begin
        if (st_end_c) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (pwr_c) begin
          state_d = (heat_lo_q || heat_hi_q) ? S_COOLDOWN : S_OFF;
        end else if (req_c && !same_c && staged_c) begin
          state_d = S_STAGE;
        end
      end
      S_STAGE: begin
        if (pwr_c) begin
          state_d = S_COOLDOWN;
          cnt_d   = '0;
        end else if (req_c) begin
          state_d = (!same_c && staged_c) ? S_STAGE : S_RUN;
          cnt_d   = '0;
        end else if (sec_end_c) begin
          cnt_d = '0;
          if (delay_q <= DLY_ONE) state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COOLDOWN: begin
        if (pwr_c) begin
          state_d = S_SELFTEST;
          cnt_d   = '0;
        end else if (sec_end_c) begin
          cnt_d = '0;
          if (delay_q <= DLY_ONE) state_d = S_OFF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values for the next cycle, registered alongside the state.
  always_comb begin
    mode_d    = mode_q;
    delay_d   = delay_q;
    fan_d     = fan_q;
    heat_lo_d = heat_lo_q;
    heat_hi_d = heat_hi_q;
    case (state_q)
      S_RUN, S_STAGE: begin
        if (pwr_c) begin
          mode_d    = MODE_NONE;
          heat_lo_d = 1'b0;
          heat_hi_d = 1'b0;
          fan_d     = (state_d == S_COOLDOWN);
          delay_d   = (state_d == S_COOLDOWN) ? COOL_LOAD : '0;
        end else if (req_c) begin
          if (same_c) begin
            mode_d    = MODE_NONE;
            delay_d   = '0;
            fan_d     = 1'b0;
            heat_lo_d = 1'b0;
            heat_hi_d = 1'b0;
          end else begin
            mode_d    = bus.key_mode;
            fan_d     = 1'b1;
            heat_lo_d = bus.key_mode[3];
            heat_hi_d = 1'b0;
            delay_d   = bus.key_mode[2] ? STRONG_DLY :
                        bus.key_mode[1] ? WARM_DLY : '0;
          end
        end else if (state_q == S_STAGE && sec_end_c) begin
          delay_d = (delay_q != '0) ? delay_q - DLY_ONE : '0;
          if (mode_q[2] && delay_q == STRONG_LO_AT) heat_lo_d = 1'b1;
          if (delay_q == DLY_ONE) begin
            if (mode_q[1] || mode_q[2]) heat_lo_d = 1'b1;
            if (mode_q[2])              heat_hi_d = 1'b1;
          end
        end
      end
      S_COOLDOWN: begin
        mode_d    = MODE_NONE;
        heat_lo_d = 1'b0;
        heat_hi_d = 1'b0;
        if (pwr_c || (sec_end_c && delay_q <= DLY_ONE)) begin
          fan_d   = 1'b0;
          delay_d = '0;
        end else if (sec_end_c) begin
          delay_d = delay_q - DLY_ONE;
        end
      end
      default: begin
        mode_d    = MODE_NONE;
        delay_d   = '0;
        fan_d     = 1'b0;
        heat_lo_d = 1'b0;
        heat_hi_d = 1'b0;
      end
    endcase

    case (state_d)
      S_SELFTEST:     on_st_d = 2'b01;
      S_RUN, S_STAGE: on_st_d = 2'b10;
      S_COOLDOWN:     on_st_d = 2'b11;
      default:        on_st_d = 2'b00;
    endcase
  end

  assign bus.on_st     = on_st_q;
  assign bus.mode_cur  = mode_q;
  assign bus.delay_sec = delay_q;
  assign bus.fan_en    = fan_q;
  assign bus.heat_lo   = heat_lo_q;
  assign bus.heat_hi   = heat_hi_q;
endmodule
